// File: rtl/hc_pkg.sv
// Shared types and Hamming helpers for the scrub controller (write-back
// behaviour selected by HC_SCRUB_WB_EN in the top level).
package hc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CHECK,
    WR_REQ,
    NEXT,
    DONE
  } hc_state_e;

  localparam int unsigned MAX_CW_WD = 64;
  localparam int unsigned MAX_SYN_WD = 8;

  function automatic int unsigned cw_wd(input int unsigned data_wd, input int unsigned chk_wd);
    return data_wd + chk_wd;
  endfunction

  // Syndrome bit i is the parity of every codeword position whose index has bit i set.
  function automatic logic [MAX_SYN_WD-1:0] calc_syndrome(input logic [MAX_CW_WD-1:0] cw,
                                                          input int unsigned cw_w,
                                                          input int unsigned chk_w);
    logic [MAX_SYN_WD-1:0] syn;
    syn = '0;
    for (int i = 0; i < int'(MAX_SYN_WD); i++) begin
      for (int j = 1; j <= int'(MAX_CW_WD); j++) begin
        if ((i < int'(chk_w)) && (j <= int'(cw_w)) && (((j >> i) & 1) == 1)) begin
          syn[i] = syn[i] ^ cw[j-1];
        end
      end
    end
    return syn;
  endfunction

  function automatic logic fix_bit(input logic b, input int unsigned pos,
                                   input logic [MAX_SYN_WD-1:0] syn);
    return b ^ ({{(32-MAX_SYN_WD){1'b0}}, syn} == pos);
  endfunction

endpackage

// File: rtl/hc_syndrome.sv
// Combinational Hamming syndrome and single-bit correction for one codeword.
module hc_syndrome
  import hc_pkg::*;
#(
  parameter int unsigned DATA_WD = 4,
  parameter int unsigned CHK_WD = 3,
  localparam int unsigned CW_WD = cw_wd(DATA_WD, CHK_WD)
) (
  input  logic [CW_WD-1:0]  i_cw,
  output logic [CHK_WD-1:0] o_syn,
  output logic [CW_WD-1:0]  o_cw_fix,
  output logic              o_err
);

  logic [MAX_CW_WD-1:0]  w_cw_ext;
  logic [MAX_SYN_WD-1:0] w_syn;

  assign w_cw_ext = MAX_CW_WD'(i_cw);
  assign w_syn    = calc_syndrome(w_cw_ext, CW_WD, CHK_WD);
  assign o_syn    = w_syn[CHK_WD-1:0];
  assign o_err    = |w_syn;

  for (genvar g = 0; g < int'(CW_WD); g++) begin : g_fix
    assign o_cw_fix[g] = fix_bit(i_cw[g], g + 1, w_syn);
  end

endmodule

// File: rtl/hc_scrub_ctrl.sv
// Memory scrubber: reads every word, counts Hamming errors and, when
// HC_SCRUB_WB_EN is defined, writes corrected codewords back.
module hc_scrub_ctrl
  import hc_pkg::*;
#(
  parameter int unsigned DATA_WD = 4,
  parameter int unsigned CHK_WD = 3,
  parameter int unsigned ADDR_WD = 4,
  localparam int unsigned CW_WD = cw_wd(DATA_WD, CHK_WD)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [ADDR_WD-1:0] o_mem_addr,
  output logic [CW_WD-1:0]   o_mem_wdata,
  input  logic               i_mem_gnt,
  input  logic               i_mem_rvalid,
  input  logic [CW_WD-1:0]   i_mem_rdata,
  output logic               o_busy,
  output logic               o_done,
  output logic [15:0]        o_corr_cnt,
  output logic [ADDR_WD-1:0] o_err_addr
);

  hc_state_e          r_state;
  logic [ADDR_WD-1:0] r_addr;
  logic [CW_WD-1:0]   r_cw;
  logic [15:0]        r_corr_cnt;
  logic [ADDR_WD-1:0] r_err_addr;
  logic               r_abort_pend;

  logic [CHK_WD-1:0]  w_syn;
  logic [CW_WD-1:0]   w_cw_fix;
  logic               w_err;

  hc_syndrome #(
    .DATA_WD(DATA_WD),
    .CHK_WD (CHK_WD)
  ) u_syndrome (
    .i_cw    (r_cw),
    .o_syn   (w_syn),
    .o_cw_fix(w_cw_fix),
    .o_err   (w_err)
  );

`ifdef HC_SCRUB_WB_EN
  logic             r_we;
  logic [CW_WD-1:0] r_wdata;
  logic             w_fixable;

  // Syndromes pointing past the codeword cannot be corrected, only counted.
  assign w_fixable   = w_err && (32'(w_syn) <= CW_WD);
  assign o_mem_we    = r_we;
  assign o_mem_wdata = r_wdata;
`else
  logic w_unused_fix;

  assign w_unused_fix = ^{w_cw_fix, w_syn};
  assign o_mem_we     = 1'b0;
  assign o_mem_wdata  = '0;
`endif

  assign o_mem_req  = (r_state == RD_REQ) || (r_state == WR_REQ);
  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);
  assign o_mem_addr = r_addr;
  assign o_corr_cnt = r_corr_cnt;
  assign o_err_addr = r_err_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_cw         <= '0;
      r_corr_cnt   <= '0;
      r_err_addr   <= '0;
      r_abort_pend <= 1'b0;
`ifdef HC_SCRUB_WB_EN
      r_we         <= 1'b0;
      r_wdata      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state      <= RD_REQ;
            r_addr       <= '0;
            r_corr_cnt   <= '0;
            r_abort_pend <= 1'b0;
          end
        end
        RD_REQ: begin
          if (i_mem_gnt) begin
            r_state      <= RD_WAIT;
            r_abort_pend <= i_abort;
          end else if (i_abort) begin
            r_state <= DONE;
          end
        end
        RD_WAIT: begin
          if (i_abort) r_abort_pend <= 1'b1;
          // An aborted read still has to drain its response before the pass ends.
          if (i_mem_rvalid) begin
            r_cw    <= i_mem_rdata;
            r_state <= (r_abort_pend || i_abort) ? DONE : CHECK;
          end
        end
        CHECK: begin
          if (i_abort) begin
            r_state <= DONE;
          end else if (w_err) begin
            if (r_corr_cnt != 16'hFFFF) r_corr_cnt <= r_corr_cnt + 16'd1;
            r_err_addr <= r_addr;
`ifdef HC_SCRUB_WB_EN
            if (w_fixable) begin
              r_state <= WR_REQ;
              r_we    <= 1'b1;
              r_wdata <= w_cw_fix;
            end else begin
              r_state <= NEXT;
            end
`else
            r_state <= NEXT;
`endif
          end else begin
            r_state <= NEXT;
          end
        end
`ifdef HC_SCRUB_WB_EN
        WR_REQ: begin
          if (i_mem_gnt) begin
            r_we    <= 1'b0;
            r_state <= i_abort ? DONE : NEXT;
          end else if (i_abort) begin
            r_we    <= 1'b0;
            r_state <= DONE;
          end
        end
`endif
        NEXT: begin
          if (i_abort || (r_addr == '1)) begin
            r_state <= DONE;
          end else begin
            r_addr  <= r_addr + ADDR_WD'(1);
            r_state <= RD_REQ;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc_scrub_ctrl.sv
// Self-checking bench for hc_scrub_ctrl with a memory responder and a
// position-XOR Hamming reference model; follows HC_SCRUB_WB_EN like the DUT.
module tb_hc_scrub_ctrl;

  localparam int AW = 4;
  localparam int CW = 7;
  localparam int NW = 16;
`ifdef HC_SCRUB_WB_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic          clk;
  logic          i_rst, i_start, i_abort;
  logic          o_mem_req, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [CW-1:0] o_mem_wdata;
  logic          i_mem_gnt, i_mem_rvalid;
  logic [CW-1:0] i_mem_rdata;
  logic          o_busy, o_done;
  logic [15:0]   o_corr_cnt;
  logic [AW-1:0] o_err_addr;

  int n_chk = 0;
  int n_fail = 0;

  logic [CW-1:0] mem[NW];
  logic [CW-1:0] img[NW];
  logic [CW-1:0] exp_mem[NW];

  bit rd_pend = 1'b0;
  bit prev_done = 1'b0;
  int rd_addr = 0, rd_wait = 0;
  int n_reads = 0, n_writes = 0, done_cnt = 0, done_long = 0, we_seen = 0;
  int stall_wr = 0, gnt_stall_pct = 0, lat_max = 0, slow_addr = -1, slow_extra = 0;
  int wr_addr_q[$];
  logic [CW-1:0] wr_data_q[$];
  int exp_wa[$];
  logic [CW-1:0] exp_wd[$];
  int e_cnt, e_err, e_wr;
  int last_err = 0;

  typedef struct {
    logic [CW-1:0] fill;
    int            bad_addr;
    logic [CW-1:0] bad_word;
    int            exp_cnt;
    int            exp_err;
  } vec_t;
  vec_t vecs[5];

  hc_scrub_ctrl #(
    .DATA_WD(4),
    .CHK_WD (3),
    .ADDR_WD(AW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_gnt   (i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_corr_cnt  (o_corr_cnt),
    .o_err_addr  (o_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: decides grant at the falling edge, so an access is
  // accepted at the next rising edge when req and gnt are both high.
  always @(negedge clk) begin
    if (i_rst) begin
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      rd_pend      = 1'b0;
      prev_done    = 1'b0;
    end else begin
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = CW'($urandom);
      if (rd_pend) begin
        if (rd_wait == 0) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = mem[rd_addr];
          rd_pend      = 1'b0;
        end else begin
          rd_wait--;
        end
      end
      i_mem_gnt = 1'b0;
      if (o_mem_req) begin
        if (o_mem_we && stall_wr > 0) stall_wr--;
        else if (int'($urandom_range(99)) >= gnt_stall_pct) i_mem_gnt = 1'b1;
      end
      if (o_mem_req && i_mem_gnt) begin
        if (o_mem_we) begin
          n_writes++;
          wr_addr_q.push_back(int'(o_mem_addr));
          wr_data_q.push_back(o_mem_wdata);
          mem[o_mem_addr] = o_mem_wdata;
        end else begin
          n_reads++;
          rd_pend = 1'b1;
          rd_addr = int'(o_mem_addr);
          rd_wait = (rd_addr == slow_addr) ? slow_extra : int'($urandom_range(lat_max));
        end
      end
      if (o_done) done_cnt++;
      if (o_done && prev_done) done_long++;
      prev_done = o_done;
      if (o_mem_we) we_seen++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference syndrome: XOR of the indices of all set positions.
  function automatic int syn_of(input logic [CW-1:0] w);
    int s = 0;
    for (int p = 1; p <= CW; p++) if (w[p-1]) s ^= p;
    return s;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [3:0] d);
    logic [CW-1:0] w = '0;
    int k = 0;
    int s;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p-1] = d[k];
        k++;
      end
    end
    s = syn_of(w);
    for (int i = 0; i < 3; i++) if (s[i]) w[(1 << i) - 1] = 1'b1;
    return w;
  endfunction

  task automatic model_pass();
    int s;
    logic [CW-1:0] fixed;
    e_cnt = 0;
    e_err = last_err;
    e_wr  = 0;
    exp_wa.delete();
    exp_wd.delete();
    for (int a = 0; a < NW; a++) begin
      exp_mem[a] = img[a];
      s = syn_of(img[a]);
      if (s != 0) begin
        e_cnt++;
        e_err = a;
        if (WB && s <= CW) begin
          fixed = img[a] ^ (CW'(1) << (s - 1));
          exp_wa.push_back(a);
          exp_wd.push_back(fixed);
          exp_mem[a] = fixed;
          e_wr++;
        end
      end
    end
  endtask

  task automatic load_image();
    for (int a = 0; a < NW; a++) mem[a] = img[a];
    wr_addr_q.delete();
    wr_data_q.delete();
    n_reads  = 0;
    n_writes = 0;
    done_cnt = 0;
    done_long = 0;
  endtask

  task automatic start_pass();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (o_done) got = 1'b1;
    end
    check({name, "_done_seen"}, longint'(got), 1);
    @(negedge clk);
    check({name, "_busy_after"}, longint'(o_busy), 0);
    check({name, "_done_width"}, longint'(o_done), 0);
  endtask

  task automatic check_pass(input string name);
    int nmis = 0;
    check({name, "_cnt"}, longint'(o_corr_cnt), e_cnt);
    check({name, "_err_addr"}, longint'(o_err_addr), e_err);
    check({name, "_reads"}, n_reads, NW);
    check({name, "_writes"}, n_writes, e_wr);
    for (int i = 0; i < wr_addr_q.size() && i < exp_wa.size(); i++) begin
      check({name, "_wr_addr"}, wr_addr_q[i], exp_wa[i]);
      check({name, "_wr_data"}, longint'(wr_data_q[i]), longint'(exp_wd[i]));
    end
    for (int a = 0; a < NW; a++) if (mem[a] !== exp_mem[a]) nmis++;
    check({name, "_mem_image"}, nmis, 0);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_done_long"}, done_long, 0);
    last_err = e_err;
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;

    vecs[0] = '{7'h55, -1, 7'h00, 0, 0};
    vecs[1] = '{7'h55, 5, 7'h45, 1, 5};
    vecs[2] = '{7'h00, 15, 7'h40, 1, 15};
    vecs[3] = '{7'h7F, 0, 7'h7E, 1, 0};
    vecs[4] = '{7'h00, 9, 7'h03, 1, 9};

    @(negedge clk);
    check("rst_req", longint'(o_mem_req), 0);
    check("rst_busy", longint'(o_busy), 0);
    check("rst_done", longint'(o_done), 0);
    check("rst_cnt", longint'(o_corr_cnt), 0);
    check("rst_err_addr", longint'(o_err_addr), 0);
    check("rst_addr", longint'(o_mem_addr), 0);
    check("rst_we", longint'(o_mem_we), 0);
    check("rst_wdata", longint'(o_mem_wdata), 0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;

    // Directed image table: zero-wait grant, one-cycle read latency.
    for (int v = 0; v < 5; v++) begin
      for (int a = 0; a < NW; a++) img[a] = vecs[v].fill;
      if (vecs[v].bad_addr >= 0) img[vecs[v].bad_addr] = vecs[v].bad_word;
      load_image();
      model_pass();
      start_pass();
      wait_done($sformatf("vec%0d", v));
      check($sformatf("vec%0d_tbl_cnt", v), longint'(o_corr_cnt), vecs[v].exp_cnt);
      check($sformatf("vec%0d_tbl_err", v), longint'(o_err_addr), vecs[v].exp_err);
      check_pass($sformatf("vec%0d", v));
    end

`ifdef HC_SCRUB_WB_EN
    // Write held off for ten cycles: request, address and data must not move.
    begin
      int wcyc = 0;
      int unstable = 0;
      bit seen = 1'b0;
      for (int a = 0; a < NW; a++) img[a] = 7'h55;
      img[5] = 7'h45;
      load_image();
      model_pass();
      stall_wr = 10;
      start_pass();
      for (int i = 0; i < 500 && !seen; i++) begin
        if (o_mem_req && o_mem_we) seen = 1'b1;
        else @(negedge clk);
      end
      check("stall_wr_seen", longint'(seen), 1);
      for (int i = 0; i < 100 && o_mem_req && o_mem_we; i++) begin
        wcyc++;
        if (o_mem_addr != AW'(5) || o_mem_wdata != 7'h55) unstable++;
        @(negedge clk);
      end
      check("stall_wr_cycles", wcyc, 11);
      check("stall_wr_unstable", unstable, 0);
      wait_done("stall");
      check_pass("stall");
      check("stall_mem5", longint'(mem[5]), 7'h55);
    end
`endif

    // Abort while a slow read of address 3 is outstanding.
    begin
      bit seen = 1'b0;
      for (int a = 0; a < NW; a++) img[a] = 7'h55;
      img[3] = 7'h45;
      img[7] = 7'h45;
      load_image();
      slow_addr  = 3;
      slow_extra = 6;
      start_pass();
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clk);
        if (o_mem_req && o_mem_addr == AW'(3)) seen = 1'b1;
      end
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (!o_mem_req && o_busy && o_mem_addr == AW'(3)) seen = 1'b1;
      end
      check("abort_rdwait_seen", longint'(seen), 1);
      i_abort = 1'b1;
      wait_done("abort");
      i_abort = 1'b0;
      slow_addr = -1;
      check("abort_cnt", longint'(o_corr_cnt), 0);
      check("abort_err_addr", longint'(o_err_addr), last_err);
      check("abort_reads", n_reads, 4);
      check("abort_writes", n_writes, 0);
      check("abort_done_pulses", done_cnt, 1);
    end

    // Randomised passes with stalls, read latency and a stray mid-pass start.
    for (int p = 0; p < 6; p++) begin
      for (int a = 0; a < NW; a++) begin
        int r = int'($urandom_range(9));
        img[a] = encode(4'($urandom_range(15)));
        if (r < 3) begin
          img[a][$urandom_range(CW - 1)] ^= 1'b1;
        end else if (r == 3) begin
          int b0 = int'($urandom_range(CW - 1));
          int b1 = (b0 + 1 + int'($urandom_range(CW - 2))) % CW;
          img[a][b0] ^= 1'b1;
          img[a][b1] ^= 1'b1;
        end
      end
      gnt_stall_pct = int'($urandom_range(60));
      lat_max       = int'($urandom_range(4));
      load_image();
      model_pass();
      start_pass();
      if (p == 2) begin
        repeat (15) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
      end
      wait_done($sformatf("rnd%0d", p));
      check_pass($sformatf("rnd%0d", p));
    end
    gnt_stall_pct = 0;
    lat_max       = 0;

    check("we_activity", longint'(we_seen > 0), longint'(WB));

    // Asynchronous reset in the middle of an access, then a fresh full pass.
    begin
      bit seen = 1'b0;
      for (int a = 0; a < NW; a++) img[a] = 7'h55;
      img[5] = 7'h45;
      load_image();
      stall_wr = 100000;
      start_pass();
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clk);
`ifdef HC_SCRUB_WB_EN
        if (o_mem_req && o_mem_we) seen = 1'b1;
`else
        if (o_mem_req && o_mem_addr == AW'(5)) seen = 1'b1;
`endif
      end
      check("mid_rst_access_seen", longint'(seen), 1);
      i_rst = 1'b1;
      #1;
      check("mid_rst_req", longint'(o_mem_req), 0);
      check("mid_rst_we", longint'(o_mem_we), 0);
      check("mid_rst_wdata", longint'(o_mem_wdata), 0);
      check("mid_rst_addr", longint'(o_mem_addr), 0);
      check("mid_rst_busy", longint'(o_busy), 0);
      check("mid_rst_cnt", longint'(o_corr_cnt), 0);
      check("mid_rst_err_addr", longint'(o_err_addr), 0);
      repeat (3) @(negedge clk);
      i_rst    = 1'b0;
      stall_wr = 0;
      last_err = 0;
      for (int a = 0; a < NW; a++) img[a] = 7'h55;
      load_image();
      model_pass();
      start_pass();
      wait_done("post_rst");
      check_pass("post_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
